// File: rtl/prism_sp_puzzle_hw_gem_ring_release_if.sv
// AXI4 write-only channel bundle (AW/W/B) used by the GEM ring-release stage.
interface prism_sp_puzzle_hw_gem_ring_release_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [ID_W-1:0]   awid;
    logic [3:0]        awcache;
    logic [2:0]        awprot;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;

    logic       bvalid;
    logic       bready;
    logic [1:0] bresp;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awid, awcache, awprot,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awid, awcache, awprot,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/prism_sp_puzzle_hw_gem_ring_release.sv
// GEM ring-release stage: writes finished descriptors back with the ownership bit set.
// Optional IRQ coalescing is enabled by defining PRISM_SP_RING_RELEASE_IRQ_COAL_EN.
module prism_sp_puzzle_hw_gem_ring_release #(
    parameter int unsigned DESC_WIDTH        = 64,
    parameter int unsigned SYSTEM_ADDR_WIDTH = 32,
    parameter int unsigned OWN_BIT           = 0,
    parameter int unsigned IRQ_COAL_THRESH   = 8,
    parameter int unsigned IRQ_COAL_TIMEOUT  = 1024
) (
    input  logic                                  clock,
    input  logic                                  resetn,
    input  logic                                  enable,
    input  logic                                  i_cookie_empty,
    output logic                                  i_cookie_rd_en,
    input  logic [SYSTEM_ADDR_WIDTH+DESC_WIDTH-1:0] i_cookie_rd_data,
    prism_sp_puzzle_hw_gem_ring_release_if.master axi,
    output logic [31:0]                           release_count,
    output logic                                  err,
    output logic                                  irq_pulse
);

    localparam int unsigned CW = SYSTEM_ADDR_WIDTH + DESC_WIDTH;
    localparam logic [DESC_WIDTH-1:0] OWN_MASK = {{(DESC_WIDTH-1){1'b0}}, 1'b1} << OWN_BIT;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    // Elaboration-time guard on parameter legality.
    if (DESC_WIDTH < 32 || (DESC_WIDTH & (DESC_WIDTH - 1)) != 0 || OWN_BIT >= DESC_WIDTH ||
        IRQ_COAL_THRESH < 1 || IRQ_COAL_THRESH > 255 || IRQ_COAL_TIMEOUT < 1) begin : g_bad_param
        $error("prism_sp_puzzle_hw_gem_ring_release: illegal parameter value");
    end

    logic [2:0]                   state_q, state_d;
    logic                         rd_en_q, rd_en_d;
    logic                         awvalid_q, awvalid_d;
    logic                         wvalid_q, wvalid_d;
    logic                         bready_q, bready_d;
    logic [SYSTEM_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DESC_WIDTH-1:0]        wdata_q, wdata_d;
    logic [31:0]                  count_q, count_d;
    logic                         err_q, err_d;
    logic                         irq_q, irq_d;
    logic                         release_ok_c;

    // Next-state and datapath: one descriptor in flight, AW and W retire independently.
    always_comb begin
        state_d      = state_q;
        rd_en_d      = 1'b0;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        count_d      = count_q;
        err_d        = err_q;
        release_ok_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable && !i_cookie_empty) begin
                    rd_en_d = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                awaddr_d  = i_cookie_rd_data[CW-1 -: SYSTEM_ADDR_WIDTH];
                wdata_d   = i_cookie_rd_data[DESC_WIDTH-1:0] | OWN_MASK;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (axi.awready) awvalid_d = 1'b0;
                if (axi.wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (axi.bvalid && bready_q) begin
                    bready_d = 1'b0;
                    state_d  = S_IDLE;
                    if (axi.bresp == RESP_OKAY) begin
                        count_d      = count_q + 32'd1;
                        release_ok_c = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef PRISM_SP_RING_RELEASE_IRQ_COAL_EN
    localparam int unsigned TMR_W = $clog2(IRQ_COAL_TIMEOUT + 1);

    logic [7:0]       batch_q, batch_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    // Coalescing: pulse on a full batch, or on idle timeout with a partial batch.
    always_comb begin
        batch_d = batch_q;
        timer_d = timer_q;
        irq_d   = 1'b0;
        if (release_ok_c) begin
            timer_d = '0;
            if (batch_q + 8'd1 == 8'(IRQ_COAL_THRESH)) begin
                irq_d   = 1'b1;
                batch_d = '0;
            end else begin
                batch_d = batch_q + 8'd1;
            end
        end else if (batch_q != 8'd0) begin
            if (timer_q == TMR_W'(IRQ_COAL_TIMEOUT - 1)) begin
                irq_d   = 1'b1;
                batch_d = '0;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            batch_q <= '0;
            timer_q <= '0;
        end else begin
            batch_q <= batch_d;
            timer_q <= timer_d;
        end
    end
`else
    always_comb irq_d = release_ok_c;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            rd_en_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            count_q   <= count_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
        end
    end

    assign i_cookie_rd_en = rd_en_q;
    assign release_count  = count_q;
    assign err            = err_q;
    assign irq_pulse      = irq_q;

    // Single-beat INCR, normal non-cacheable bufferable, full strobes.
    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = 3'($clog2(DESC_WIDTH / 8));
    assign axi.awburst = 2'b01;
    assign axi.awid    = '0;
    assign axi.awcache = 4'b0011;
    assign axi.awprot  = 3'b000;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = '1;
    assign axi.wlast   = 1'b1;
    assign axi.bready  = bready_q;

endmodule

// File: tb/tb_prism_sp_puzzle_hw_gem_ring_release.sv
// Scoreboard bench for the GEM ring-release stage: cookie FIFO model, AXI write slave, monitor.
module tb_prism_sp_puzzle_hw_gem_ring_release;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = AW + DW;

    logic          clock = 1'b0;
    logic          resetn = 1'b1;
    logic          enable = 1'b0;
    logic          i_cookie_empty = 1'b1;
    logic          i_cookie_rd_en;
    logic [CW-1:0] i_cookie_rd_data = '0;
    logic [31:0]   release_count;
    logic          err;
    logic          irq_pulse;

    prism_sp_puzzle_hw_gem_ring_release_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

    prism_sp_puzzle_hw_gem_ring_release #(
        .DESC_WIDTH(DW), .SYSTEM_ADDR_WIDTH(AW), .OWN_BIT(0),
        .IRQ_COAL_THRESH(4), .IRQ_COAL_TIMEOUT(16)
    ) u_dut (
        .clock(clock), .resetn(resetn), .enable(enable),
        .i_cookie_empty(i_cookie_empty), .i_cookie_rd_en(i_cookie_rd_en),
        .i_cookie_rd_data(i_cookie_rd_data), .axi(axi),
        .release_count(release_count), .err(err), .irq_pulse(irq_pulse)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic [CW-1:0] fifo_q[$];
    logic [AW-1:0] exp_aw_q[$];
    logic [DW-1:0] exp_w_q[$];
    int issued = 0, resolved = 0, aw_tot = 0, w_num = 0, b_num = 0;
    int slow_w_write = -1, slverr_write = -1;
    bit b_hold = 1'b0, b_hs = 1'b0, aw_done = 1'b0, w_done = 1'b0;
    int b_pend = 0, w_cnt = 0;
    int exp_count = 0;
    bit exp_err = 1'b0, irq_exp = 1'b0, cnt_chk = 1'b0, en_prev = 1'b0;
    int rd_cnt = 0, cyc = 0, last_rel_cyc = 0;
    int pulse_rel[$];
    int pulse_dly[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] exp_d);
        fifo_q.push_back({a, d});
        exp_aw_q.push_back(a);
        exp_w_q.push_back(exp_d);
        issued++;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (resolved < issued && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (resolved < issued) chk({name, "_timeout"}, 64'(resolved), 64'(issued));
        repeat (3) @(negedge clock);
    endtask

    // Bench-side bookkeeping after an asynchronous reset of the DUT.
    task automatic clear_after_reset();
        b_hold = 1'b0; b_pend = 0; b_hs = 1'b0; axi.bvalid = 1'b0;
        aw_done = 1'b0; w_done = 1'b0; w_cnt = 0;
        exp_aw_q.delete(); exp_w_q.delete(); fifo_q.delete();
        resolved = issued; exp_count = 0; exp_err = 1'b0;
        cnt_chk = 1'b0; irq_exp = 1'b0;
    endtask

    // Cookie FIFO model: data appears the cycle after the read strobe.
    always @(negedge clock) begin
        if (i_cookie_rd_en) begin
            if (fifo_q.size() == 0) chk("rd_en_on_empty_fifo", 64'(i_cookie_rd_en), 64'd0);
            else i_cookie_rd_data = fifo_q.pop_front();
        end
        i_cookie_empty = (fifo_q.size() == 0);
    end

    // AXI write slave: AW always ready, W optionally delayed, B after both handshakes.
    always @(negedge clock) begin
        int dly;
        if (b_hs) begin
            axi.bvalid = 1'b0;
            b_hs = 1'b0;
            b_num++;
        end
        if (!axi.bvalid && b_pend > 0 && !b_hold) begin
            axi.bvalid = 1'b1;
            axi.bresp  = (b_num == slverr_write) ? 2'b10 : 2'b00;
            b_pend--;
        end
        if (axi.bvalid && axi.bready) b_hs = 1'b1;
        if (axi.awvalid) aw_done = 1'b1;
        dly = (w_num == slow_w_write) ? 3 : 0;
        axi.wready = axi.wvalid && (w_cnt >= dly);
        if (axi.wvalid && !axi.wready) w_cnt++;
        if (axi.wready) begin
            w_cnt = 0;
            w_num++;
            w_done = 1'b1;
        end
        if (aw_done && w_done) begin
            b_pend++;
            aw_done = 1'b0;
            w_done = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on each handshake the DUT takes part in.
    always @(negedge clock) begin
        #1;
        cyc++;
        if (cnt_chk) begin
            chk("release_count", 64'(release_count), 64'(exp_count));
            chk("err", 64'(err), 64'(exp_err));
            cnt_chk = 1'b0;
        end
`ifndef PRISM_SP_RING_RELEASE_IRQ_COAL_EN
        if (irq_pulse || irq_exp) chk("irq_pulse", 64'(irq_pulse), 64'(irq_exp));
`else
        if (irq_pulse) begin
            pulse_rel.push_back(exp_count);
            pulse_dly.push_back(cyc - last_rel_cyc);
        end
`endif
        irq_exp = 1'b0;
        if (i_cookie_rd_en) begin
            rd_cnt++;
            if (!en_prev) chk("rd_en_while_disabled", 64'(i_cookie_rd_en), 64'd0);
        end
        en_prev = enable;
        if (axi.awvalid && axi.awready) begin
            chk("aw_outstanding", 64'(aw_tot - resolved), 64'd0);
            aw_tot++;
            if (exp_aw_q.size() == 0) chk("aw_unexpected", 64'(axi.awvalid), 64'd0);
            else chk("awaddr", 64'(axi.awaddr), 64'(exp_aw_q.pop_front()));
            chk("awlen", 64'(axi.awlen), 64'd0);
            chk("awsize", 64'(axi.awsize), 64'd3);
            chk("awburst", 64'(axi.awburst), 64'd1);
            chk("awcache", 64'(axi.awcache), 64'd3);
            chk("awid_awprot", 64'({axi.awid, axi.awprot}), 64'd0);
        end
        if (axi.wvalid && axi.wready) begin
            if (exp_w_q.size() == 0) chk("w_unexpected", 64'(axi.wvalid), 64'd0);
            else chk("wdata", axi.wdata, exp_w_q.pop_front());
            chk("wstrb_wlast", 64'({axi.wstrb, axi.wlast}), 64'h1FF);
        end
        if (axi.bvalid && axi.bready) begin
            resolved++;
            cnt_chk = 1'b1;
            if (axi.bresp == 2'b00) begin
                exp_count++;
                irq_exp = 1'b1;
                last_rel_cyc = cyc + 1;
            end else begin
                exp_err = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        axi.awready = 1'b1; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        #2 resetn = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_rd_en", 64'(i_cookie_rd_en), 64'd0);
        chk("rst_valids_bready", 64'({axi.awvalid, axi.wvalid, axi.bready}), 64'd0);
        chk("rst_release_count", 64'(release_count), 64'd0);
        chk("rst_err_irq", 64'({err, irq_pulse}), 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        enable = 1'b1;

        // Single cookie, all sinks ready.
        rd_cnt = 0;
        push(32'h1000_0040, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001);
        wait_done("t1", 60);
        chk("t1_release_count", 64'(release_count), 64'd1);
        chk("t1_rd_en_pulses", 64'(rd_cnt), 64'd1);

        // Four back-to-back, W of the second write stalls three cycles.
        base = aw_tot;
        slow_w_write = w_num + 1;
        push(32'h1000_0080, 64'hDEAD_BEEF_0000_0010, 64'hDEAD_BEEF_0000_0011);
        push(32'h1000_00C0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        push(32'h1000_0100, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
        push(32'h1000_0140, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001);
        wait_done("t2", 200);
        slow_w_write = -1;
        chk("t2_release_count", 64'(release_count), 64'd5);
        chk("t2_writes", 64'(aw_tot - base), 64'd4);

        // SLVERR on the second of three.
        base = aw_tot;
        slverr_write = b_num + 1;
        push(32'h1000_0180, 64'h0000_0000_0000_00A0, 64'h0000_0000_0000_00A1);
        push(32'h1000_01C0, 64'h0000_0000_0000_00B0, 64'h0000_0000_0000_00B1);
        push(32'h1000_0200, 64'h0000_0000_0000_00C0, 64'h0000_0000_0000_00C1);
        wait_done("t3", 200);
        slverr_write = -1;
        chk("t3_release_count", 64'(release_count), 64'd7);
        chk("t3_err", 64'(err), 64'd1);
        chk("t3_writes", 64'(aw_tot - base), 64'd3);
        repeat (5) @(negedge clock);
        chk("t3_err_sticky", 64'(err), 64'd1);

        // enable dropped while the first of two writes is in SEND.
        rd_cnt = 0;
        push(32'h1000_0240, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_1001);
        push(32'h1000_0280, 64'h0000_0000_0000_2000, 64'h0000_0000_0000_2001);
        n = 0;
        while (!axi.awvalid && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("t4_reach_send", 64'(axi.awvalid), 64'd1);
        enable = 1'b0;
        repeat (20) @(negedge clock);
        chk("t4_count_while_disabled", 64'(release_count), 64'd8);
        chk("t4_cookie_left_in_fifo", 64'(fifo_q.size()), 64'd1);
        chk("t4_rd_en_pulses_disabled", 64'(rd_cnt), 64'd1);
        enable = 1'b1;
        wait_done("t4", 80);
        chk("t4_release_count", 64'(release_count), 64'd9);
        chk("t4_rd_en_pulses", 64'(rd_cnt), 64'd2);

        // Asynchronous reset while waiting in RESP.
        b_hold = 1'b1;
        push(32'h1000_02C0, 64'h0000_0000_0000_0100, 64'h0000_0000_0000_0101);
        n = 0;
        while (!axi.bready && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("t5_reach_resp", 64'(axi.bready), 64'd1);
        #2 resetn = 1'b0;
        #1;
        chk("t5_rst_valids_bready", 64'({axi.awvalid, axi.wvalid, axi.bready}), 64'd0);
        chk("t5_rst_release_count", 64'(release_count), 64'd0);
        chk("t5_rst_err", 64'(err), 64'd0);
        clear_after_reset();
        @(negedge clock);
        resetn = 1'b1;
        push(32'h1000_0300, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0003);
        wait_done("t5", 60);
        chk("t5_restart_count", 64'(release_count), 64'd1);
        chk("t5_restart_err", 64'(err), 64'd0);

`ifdef PRISM_SP_RING_RELEASE_IRQ_COAL_EN
        // Coalescing: threshold 4, timeout 16, ten releases.
        @(negedge clock);
        resetn = 1'b0;
        #1;
        clear_after_reset();
        @(negedge clock);
        resetn = 1'b1;
        pulse_rel.delete();
        pulse_dly.delete();
        for (int i = 0; i < 10; i++)
            push(32'h2000_0000 + 32'(i * 8), 64'(i * 16), 64'(i * 16 + 1));
        wait_done("coal", 400);
        repeat (30) @(negedge clock);
        chk("coal_pulses", 64'(pulse_rel.size()), 64'd3);
        if (pulse_rel.size() >= 3) begin
            chk("coal_p0_release", 64'(pulse_rel[0]), 64'd4);
            chk("coal_p0_delay", 64'(pulse_dly[0]), 64'd0);
            chk("coal_p1_release", 64'(pulse_rel[1]), 64'd8);
            chk("coal_p1_delay", 64'(pulse_dly[1]), 64'd0);
            chk("coal_p2_release", 64'(pulse_rel[2]), 64'd10);
            chk("coal_p2_delay", 64'(pulse_dly[2]), 64'd16);
        end
`endif

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prism_sp_puzzle_hw_gem_ring_release.md
Name: prism_sp_puzzle_hw_gem_ring_release

Overview:
- Stage directly downstream of the GEM ring-acquire stage.
- Consumes descriptor cookies after the processing puzzle has finished with them.
- Writes each descriptor back to memory over AXI with the ownership/used bit set, returning it to the GEM.
- Strictly in-order, one outstanding single-beat AXI write at a time.
- Counts released descriptors and raises a completion pulse for the interrupt logic.

Parameters:
- DESC_WIDTH, 64, descriptor width in bits; must equal the AXI write data width and be a power of two ≥ 32.
- OWN_BIT, 0, bit index in the descriptor forced to 1 on writeback.
- IRQ_COAL_THRESH, 8, releases per IRQ pulse (used only with the optional feature); range 1..255.
- IRQ_COAL_TIMEOUT, 1024, clocks after the last release before a partial-batch IRQ (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  level; when low, no new cookie is fetched.
- i_cookie_empty  in  1  cookie FIFO empty.
- i_cookie_rd_en  out  1  FIFO read strobe; data is valid the following cycle.
- i_cookie_rd_data  in  SYSTEM_ADDR_WIDTH+DESC_WIDTH  cookie: {desc_addr, desc_word}.
- axi_aw (awvalid/awready/awaddr/awlen/awsize/awburst/awid/awcache/awprot)  master  -  write address channel.
- axi_w (wvalid/wready/wdata/wstrb/wlast)  master  -  write data channel.
- axi_b (bvalid/bready/bresp)  master  -  write response channel.
- release_count  out  32  count of descriptors released with OKAY.
- err  out  1  sticky; set on any bresp ≠ OKAY.
- irq_pulse  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, resetn=0): state=IDLE, i_cookie_rd_en=0, awvalid=0, wvalid=0, bready=0, release_count=0, err=0, irq_pulse=0. A reset during an AXI transaction drops the valids immediately; this is allowed only at system reset.
- Constant AXI fields: awlen=0, awsize=$clog2(DESC_WIDTH/8), awburst=INCR, awid=0, awcache=4'b0011, awprot=0, wstrb=all ones, wlast=1.
- States:
  - IDLE: if enable && !i_cookie_empty, pulse i_cookie_rd_en for 1 cycle → FETCH.
  - FETCH: FIFO presents data → LATCH.
  - LATCH: register awaddr=desc_addr and wdata=desc_word | (1<<OWN_BIT); assert awvalid and wvalid together → SEND.
  - SEND: awvalid and wvalid drop independently on their own handshake; when both handshakes are done (same or different cycles), bready=1 → RESP.
  - RESP: on bvalid && bready, bready=0 → IDLE.
    - bresp==OKAY: release_count += 1 (wraps at 2^32).
    - bresp≠OKAY: err=1; count not incremented.
- Latency: cookie present in IDLE to awvalid = 3 cycles. Minimum cycles per descriptor = 5 with ready sinks.
- irq_pulse (feature off): high the cycle after each OKAY response.
- enable falling mid-transaction: the current descriptor completes; the block then stays in IDLE.
- i_cookie_empty asserted in FETCH/LATCH is ignored, since the read was already committed.
- The block never asserts rd_en while not in IDLE, so at most one read is in flight.

Optional Feature:
- Macro: PRISM_SP_RING_RELEASE_IRQ_COAL_EN.
- Defined:
  - An 8-bit batch counter increments on each OKAY release.
  - irq_pulse fires when the counter reaches IRQ_COAL_THRESH, or when the counter is nonzero and IRQ_COAL_TIMEOUT clocks have elapsed since the last release.
  - Both the counter and the timer clear on the pulse.
  - If the threshold and the timeout coincide, exactly one pulse is generated.
- Undefined: one pulse per OKAY release; the counter and timer logic is absent.

Test Plan:
- Single cookie {addr=0x1000_0040, desc=0x0000_0000_0000_0000}, AXI always ready → one write: awaddr=0x1000_0040, wdata=0x1, awlen=0. Then release_count=1, irq_pulse high for exactly 1 cycle, i_cookie_rd_en pulsed once.
- 4 back-to-back cookies; wready delayed 3 cycles behind awready on the 2nd write → 4 writes in FIFO order, no second awvalid before the prior bvalid, release_count=4.
- bresp=SLVERR on the 2nd of 3 cookies → err=1 and stays set, release_count=2, 3 writes issued.
- enable dropped in the SEND cycle with 2 cookies queued → the current write completes, rd_en stays 0 while enable=0, and the second cookie is processed after enable=1.
- Reset asserted in RESP → all valids, bready, release_count and err read 0 in the same cycle (asynchronous); after release the block restarts from IDLE.
- With PRISM_SP_RING_RELEASE_IRQ_COAL_EN, THRESH=4, TIMEOUT=16:
  - 10 releases → pulses after the 4th and 8th release.
  - A further pulse comes 16 clocks after the 10th release.
  - Total pulses = 3.
